// File: rtl/pdn_rail_sequencer.sv
// Staggered power-switch sequencer for one block on the five-rail supply network.
// Optional build macro PDN_SEQ_TIMEOUT_EN adds a pg-wait timeout that faults the stuck rail.
module pdn_rail_sequencer #(
    parameter int unsigned NUM_RAILS      = 5,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pwr_req,
    input  logic [NUM_RAILS-1:0] rail_pg,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 pwr_ack,
    output logic                 busy,
    output logic                 fault,
    output logic [2:0]           fault_rail
);

    typedef enum logic [2:0] {
        StOff,
        StRampUp,
        StOn,
        StRampDown,
        StFault
    } state_e;

    localparam logic [2:0]       LastIdx     = 3'(NUM_RAILS - 1);
    localparam logic [CNT_W-1:0] SettleLast  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax      = '1;

`ifdef PDN_SEQ_TIMEOUT_EN
    localparam logic TimeoutEn = 1'b1;
`else
    localparam logic TimeoutEn = 1'b0;
`endif

    state_e               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 settling_q, settling_d;
    logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 fault_q, fault_d;
    logic [2:0]           fault_rail_q, fault_rail_d;

    logic [NUM_RAILS-1:0] cur_bit;
    logic [NUM_RAILS-1:0] chk_mask;
    logic [NUM_RAILS-1:0] chk_low;
    logic                 pg_cur;
    logic [CNT_W-1:0]     settle_cnt;
    logic                 timeout_hit;
    logic                 go_fault;
    logic [2:0]           fault_idx;

    function automatic logic [2:0] lowest_set(input logic [NUM_RAILS-1:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = int'(NUM_RAILS) - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

    // Rails below idx are settled and enabled; idx itself is watched only once it has settled once.
    always_comb begin
        cur_bit     = NUM_RAILS'(1) << idx_q;
        chk_mask    = (rail_en_q & ~cur_bit) | (settling_q ? cur_bit : '0);
        chk_low     = chk_mask & ~rail_pg;
        pg_cur      = |(rail_pg & cur_bit);
        settle_cnt  = settling_q ? cnt_q : '0;
        timeout_hit = TimeoutEn && !settling_q && !pg_cur && (cnt_q == TimeoutLast);
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        settling_d   = settling_q;
        rail_en_d    = rail_en_q;
        ack_d        = ack_q;
        busy_d       = busy_q;
        fault_d      = fault_q;
        fault_rail_d = fault_rail_q;
        go_fault     = 1'b0;
        fault_idx    = '0;

        unique case (state_q)
            StOff: begin
                if (pwr_req) begin
                    state_d    = StRampUp;
                    idx_d      = '0;
                    cnt_d      = '0;
                    settling_d = 1'b0;
                    rail_en_d  = NUM_RAILS'(1);
                    busy_d     = 1'b1;
                end
            end

            StRampUp: begin
                if (|chk_low) begin
                    go_fault  = 1'b1;
                    fault_idx = lowest_set(chk_low);
                end else if (timeout_hit) begin
                    go_fault  = 1'b1;
                    fault_idx = idx_q;
                end else if (!pwr_req) begin
                    // Rails 0..idx are on, so idx is the highest enabled rail.
                    state_d    = StRampDown;
                    rail_en_d  = rail_en_q & ~cur_bit;
                    cnt_d      = '0;
                    settling_d = 1'b0;
                end else if (pg_cur) begin
                    if (settle_cnt == SettleLast) begin
                        cnt_d      = '0;
                        settling_d = 1'b0;
                        if (idx_q == LastIdx) begin
                            state_d = StOn;
                            ack_d   = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            idx_d     = idx_q + 3'd1;
                            rail_en_d = rail_en_q | (cur_bit << 1);
                        end
                    end else begin
                        cnt_d      = settle_cnt + 1'b1;
                        settling_d = 1'b1;
                    end
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StOn: begin
                if (!(&rail_pg)) begin
                    go_fault  = 1'b1;
                    fault_idx = lowest_set(~rail_pg);
                end else if (!pwr_req) begin
                    state_d   = StRampDown;
                    rail_en_d = rail_en_q & ~cur_bit;
                    ack_d     = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                end
            end

            StRampDown: begin
                // idx names the rail most recently disabled; pg is not consulted here.
                if (cnt_q >= SettleLast) begin
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        state_d = StOff;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d     = idx_q - 3'd1;
                        rail_en_d = rail_en_q & ~(cur_bit >> 1);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StFault: begin
                if (!pwr_req) begin
                    state_d      = StOff;
                    fault_d      = 1'b0;
                    fault_rail_d = '0;
                    idx_d        = '0;
                    cnt_d        = '0;
                end
            end

            default: begin
                state_d = StOff;
            end
        endcase

        if (go_fault) begin
            state_d      = StFault;
            rail_en_d    = '0;
            ack_d        = 1'b0;
            busy_d       = 1'b0;
            fault_d      = 1'b1;
            fault_rail_d = fault_idx;
            cnt_d        = '0;
            settling_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StOff;
            idx_q        <= '0;
            cnt_q        <= '0;
            settling_q   <= 1'b0;
            rail_en_q    <= '0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_rail_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            settling_q   <= settling_d;
            rail_en_q    <= rail_en_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
            fault_rail_q <= fault_rail_d;
        end
    end

    assign rail_en    = rail_en_q;
    assign pwr_ack    = ack_q;
    assign busy       = busy_q;
    assign fault      = fault_q;
    assign fault_rail = fault_rail_q;

endmodule

// File: doc/pdn_rail_sequencer.md
Name: pdn_rail_sequencer

Overview:
- Block-side power-up/power-down sequencer for one instance on the five-rail supply network (rails A..E, fed from VDD1..VDD5).
- The top level distributes the rails. This block is the consumer end: it drives the per-rail power-switch enables in a fixed staggered order to limit inrush, and checks per-rail power-good.
- Reports a single power acknowledge to block logic.
- One instance sits inside each block; twenty instances exist at chip level.

Parameters:
- NUM_RAILS, 5, number of switched rails; index 0 = VDD_A … 4 = VDD_E.
- SETTLE_CYCLES, 16, consecutive cycles a rail's pg must be high before the next rail is enabled; also the fixed wait after each rail disable on ramp-down.
- TIMEOUT_CYCLES, 255, maximum cycles from a rail enable to its first pg high.
- CNT_W, 8, counter width; must hold max(SETTLE_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  input  1  block clock.
- rst_n  input  1  asynchronous active-low reset.
- pwr_req  input  1  level request: 1 = block wants power on, 0 = off.
- rail_pg  input  NUM_RAILS  per-rail power-good from the switch; synchronous to clk.
- rail_en  output  NUM_RAILS  per-rail switch enable, registered.
- pwr_ack  output  1  all rails up and settled.
- busy  output  1  high in RAMP_UP or RAMP_DOWN.
- fault  output  1  sticky fault flag.
- fault_rail  output  3  index of the faulting rail.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset state: OFF, rail_en=0, pwr_ack=0, busy=0, fault=0, fault_rail=0, idx=0, cnt=0. All outputs are registered.
- States: OFF, RAMP_UP, ON, RAMP_DOWN, FAULT.
- OFF:
  - pwr_req=1 at an edge → RAMP_UP with idx=0.
  - rail_en[0] goes high at that same edge.
- RAMP_UP, per rail idx:
  - cnt counts cycles while rail_pg[idx]=0.
  - The first cycle rail_pg[idx]=1 is sampled counts as settle sample 1.
  - After SETTLE_CYCLES consecutive high samples, at the next edge:
    - if idx<NUM_RAILS-1: idx+1 and rail_en[idx+1]=1;
    - else → ON with pwr_ack=1.
  - rail_pg[idx] dropping during settle → FAULT, fault_rail=idx.
  - rail_pg of any already-settled rail dropping → FAULT with that index; lowest index wins.
  - pwr_req=0 at any point → RAMP_DOWN starting from the highest currently enabled rail.
- ON:
  - Any rail_pg bit low → FAULT; fault_rail = lowest low index.
  - pwr_req=0 → RAMP_DOWN. pwr_ack drops at the same edge the top rail's enable drops.
- RAMP_DOWN:
  - Disable rails in reverse order, one every SETTLE_CYCLES cycles.
  - rail_pg is ignored.
  - After rail 0 is disabled and its SETTLE_CYCLES wait ends → OFF.
  - pwr_req returning to 1 mid-ramp-down does not abort; the block completes to OFF, then re-enters RAMP_UP on the following edge.
- FAULT:
  - All rail_en cleared at the entry edge; pwr_ack=0, busy=0, fault=1.
  - fault_rail is latched at entry and held.
  - Exits to OFF only after pwr_req is sampled 0. fault clears on that exit edge.
- Simultaneous pg drops on several rails: the lowest index is reported.
- rst_n assertion mid-sequence: all enables drop immediately (asynchronously) and the block returns to reset state.
- Counters saturate; they never wrap.

Optional Feature:
- Macro PDN_SEQ_TIMEOUT_EN.
- Defined: in RAMP_UP, if rail_pg[idx] stays 0 for TIMEOUT_CYCLES cycles after rail_en[idx] rises → FAULT with fault_rail=idx.
- Undefined: no timeout. The sequencer waits indefinitely for pg; only pwr_req=0 or reset leaves the wait. TIMEOUT_CYCLES is unused.

Test Plan:
- Nominal power-up. Setup: SETTLE_CYCLES=4; pg model follows rail_en with 2-cycle delay; pwr_req rises before edge 0. Required response: rail_en[n] rises at edge 6n; pwr_ack rises at edge 30; busy is high for edges 0–29.
- Power-down from ON. Stimulus: pwr_req=0 before edge k. Required response: rail_en[4] and pwr_ack drop at edge k; rail_en[3..0] drop at k+4, k+8, k+12, k+16; OFF and busy=0 at k+20.
- Abort during ramp-up. Stimulus: pwr_req=0 sampled while idx=2 is settling. Required response: rail_en[2], [1], [0] drop 4 cycles apart, then OFF; pwr_ack never asserts.
- pg glitch in ON. Stimulus: force rail_pg[1] and rail_pg[3] low in the same cycle. Required response: next edge rail_en=0, fault=1, fault_rail=1; fault holds while pwr_req=1 and clears one edge after pwr_req=0.
- Timeout (PDN_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=20). Stimulus: hold rail_pg[2]=0. Required response: FAULT with fault_rail=2 exactly 20 cycles after rail_en[2] rises. With the macro undefined, the block stays in RAMP_UP with busy=1.
- Async reset. Stimulus: drop rst_n mid-RAMP_UP. Required response: rail_en=0 without waiting for a clock edge; on release, all outputs are 0 and the state is OFF.
